// File: rtl/oled_bus_arbiter.sv
// rtl/oled_bus_arbiter.sv - three-port Pmod OLED SPI bus arbiter with guard gap and watchdog
module oled_bus_arbiter #(
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 2**20,
    parameter int TW      = 21
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] REQ,
    input  logic [2:0] DONE,
    input  logic [2:0] CS_IN,
    input  logic [2:0] SDO_IN,
    input  logic [2:0] SCLK_IN,
    input  logic [2:0] DC_IN,
    output logic [2:0] GNT,
    output logic       CS,
    output logic       SDO,
    output logic       SCLK,
    output logic       DC,
    output logic       BUSY,
    output logic       TIMEOUT_ERR
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    logic [1:0]    state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic          last2_q, last2_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          err_q, err_d;
    logic          cs_q, cs_d, sdo_q, sdo_d, sclk_q, sclk_d, dc_q, dc_d;
    logic [2:0]    sel;
    logic          owner_done, owner_drop, wd_exp;

    // Port 0 always wins; ports 1/2 alternate on a tie via the last-served flag
    always_comb begin
        sel = 3'b000;
        if (REQ[0])
            sel = 3'b001;
        else if (REQ[1] && REQ[2])
            sel = last2_q ? 3'b010 : 3'b100;
        else if (REQ[1])
            sel = 3'b010;
        else if (REQ[2])
            sel = 3'b100;
    end

    assign owner_done = |(DONE & gnt_q);
    assign owner_drop = ~|(REQ & gnt_q);
    assign wd_exp     = (wd_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last2_d = last2_q;
        wd_d    = wd_q;
        guard_d = guard_q;
        err_d   = err_q;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
        sdo_d   = 1'b0;
        dc_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    state_d = S_GRANT;
                    gnt_d   = sel;
                    wd_d    = '0;
                    if (sel[1] || sel[2])
                        last2_d = sel[2];
                end
            end
            S_GRANT: begin
                // A clean completion outranks a coincident watchdog expiry
                if (owner_done || owner_drop || wd_exp) begin
                    state_d = S_RELEASE;
                    gnt_d   = 3'b000;
                    guard_d = '0;
                    if (!owner_done && !owner_drop)
                        err_d = 1'b1;
                end else begin
                    wd_d   = wd_q + TW'(1);
                    cs_d   = |(CS_IN & gnt_q);
                    sdo_d  = |(SDO_IN & gnt_q);
                    sclk_d = |(SCLK_IN & gnt_q);
                    dc_d   = |(DC_IN & gnt_q);
                end
            end
            S_RELEASE: begin
                if (guard_q == GW'(GUARD - 1))
                    state_d = S_IDLE;
                else
                    guard_d = guard_q + GW'(1);
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            gnt_q   <= 3'b000;
            last2_q <= 1'b1;
            wd_q    <= '0;
            guard_q <= '0;
            err_q   <= 1'b0;
            cs_q    <= 1'b1;
            sdo_q   <= 1'b0;
            sclk_q  <= 1'b1;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last2_q <= last2_d;
            wd_q    <= wd_d;
            guard_q <= guard_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            sdo_q   <= sdo_d;
            sclk_q  <= sclk_d;
            dc_q    <= dc_d;
        end
    end

    assign GNT         = gnt_q;
    assign CS          = cs_q;
    assign SDO         = sdo_q;
    assign SCLK        = sclk_q;
    assign DC          = dc_q;
    assign BUSY        = (state_q != S_IDLE);
    assign TIMEOUT_ERR = err_q;

endmodule
